// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data/stop sampling with a registered done pulse
// and framing-error flag. Pairs with the shared baud tick generator.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err
);

    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [7:0]      b_q, b_d;
    logic [7:0]      dout_q, dout_d;
    logic            frame_err_q, frame_err_d;
    logic            done_q, done_d;
    logic            rx_meta, rx_s;

    // rx is asynchronous to clk; idle level is 1 so the synchronizer resets high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Start detection is not tick-gated so the mid-bit count starts promptly
                if (!rx_s) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s) begin
                            state_d = StData;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[7:1]};
                        if (n_q == 3'(DBIT - 1)) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d     = StIdle;
                        // Short frames fill from the top; right-align into dout
                        dout_d      = b_q >> (8 - DBIT);
                        frame_err_d = ~rx_s;
                        done_d      = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dout         = dout_q;
    assign frame_err    = frame_err_q;
    assign rx_done_tick = done_q;

endmodule
